ecc_write_arbiter: RTL and testbench

ECC_WRITE_ARBITER -- requirements
Module: ecc_write_arbiter

---
 rtl/ecc_write_arbiter_pkg.sv | 39 +++
 rtl/ecc_write_arbiter_enc.sv | 40 ++++
 rtl/ecc_write_arbiter.sv | 113 +++++++++++
 tb/tb_ecc_write_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_write_arbiter_pkg.sv
// Shared ECC definitions: code/data widths, parity positions, parity masks, FSM states.
// Latency: none (constants and a constant-evaluated helper function only).
// Backpressure: not applicable.
package ecc_write_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 38;

    // Parity bit locations inside the codeword (0-based bit index)
    localparam int P1_POS  = 0;
    localparam int P2_POS  = 1;
    localparam int P4_POS  = 3;
    localparam int P8_POS  = 7;
    localparam int P16_POS = 15;
    localparam int P32_POS = 31;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Coverage mask of parity group k: codeword bits whose 1-based position has
    // bit k set. The established encoder leaves D0 (bit 2) out of the P2 group,
    // and downstream checkers are built against that exact mask.
    function automatic logic [CODE_W-1:0] par_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int b = 0; b < CODE_W; b++) begin
            if ((((b + 1) >> k) & 1) == 1) begin
                m = m | (CODE_W'(1) << b);
            end
        end
        if (k == 1) begin
            m = m & ~(CODE_W'(1) << 2);
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_write_arbiter_enc.sv
// Combinational 32->38 Hamming encoder: data bits placed around six parity bits.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input directly.
module ecc_write_arbiter_enc
    import ecc_write_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    localparam logic [CODE_W-1:0] M_P1  = par_mask(0);
    localparam logic [CODE_W-1:0] M_P2  = par_mask(1);
    localparam logic [CODE_W-1:0] M_P4  = par_mask(2);
    localparam logic [CODE_W-1:0] M_P8  = par_mask(3);
    localparam logic [CODE_W-1:0] M_P16 = par_mask(4);
    localparam logic [CODE_W-1:0] M_P32 = par_mask(5);

    logic [CODE_W-1:0] raw;
    logic [5:0]        par;

    // Data bits in their codeword slots, parity slots left at zero
    assign raw = {data[31:26], 1'b0, data[25:11], 1'b0, data[10:4], 1'b0,
                  data[3:1], 1'b0, data[0], 1'b0, 1'b0};

    assign par[0] = ^(raw & M_P1);
    assign par[1] = ^(raw & M_P2);
    assign par[2] = ^(raw & M_P4);
    assign par[3] = ^(raw & M_P8);
    assign par[4] = ^(raw & M_P16);
    assign par[5] = ^(raw & M_P32);

    assign code = raw
                | (CODE_W'(par[0]) << P1_POS)
                | (CODE_W'(par[1]) << P2_POS)
                | (CODE_W'(par[2]) << P4_POS)
                | (CODE_W'(par[3]) << P8_POS)
                | (CODE_W'(par[4]) << P16_POS)
                | (CODE_W'(par[5]) << P32_POS);

endmodule

// File: rtl/ecc_write_arbiter.sv
// Round-robin arbiter of two write requesters into one shared ECC encode and output register.
// Latency: one cycle from request handshake to out_valid.
// Backpressure: requester ready = output empty or being consumed; stalled requesters hold their own data.
module ecc_write_arbiter
    import ecc_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_W-1:0]    req0_data,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_W-1:0]    req1_data,
    input  logic [ADDR_W-1:0]    req1_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CODE_W-1:0]    out_code,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_src,
    input  logic                 err_inj_en,
    input  logic [5:0]           err_inj_pos,
    output logic [15:0]          word_cnt
);

    out_state_t        state, state_nxt;
    logic              last_grant;
    logic              can_accept;
    logic              grant_vld;
    logic              grant;
    logic              take;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_addr;
    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] flip;

    assign out_valid  = (state == ST_FULL);
    assign can_accept = !out_valid || out_ready;

    // Grant selection: sole requester wins, ties alternate away from last_grant;
    // nothing is granted while reset is held so both readies drop immediately.
    always_comb begin
        grant_vld = rst_n && (req0_valid || req1_valid);
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign take       = grant_vld && can_accept;
    assign req0_ready = take && (grant == 1'b0);
    assign req1_ready = take && (grant == 1'b1);

    assign sel_data = grant ? req1_data : req0_data;
    assign sel_addr = grant ? req1_addr : req0_addr;

    ecc_write_arbiter_enc u_enc (
        .data (sel_data),
        .code (enc_code)
    );

    // Out-of-range injection positions flip nothing
    assign flip = (err_inj_en && (err_inj_pos < 6'(CODE_W))) ? (CODE_W'(1) << err_inj_pos) : '0;

    // Output FSM next state: fill on accept, drain on consume without refill
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (take) state_nxt = ST_FULL;
            ST_FULL:  if (!take && out_ready) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word capture and round-robin history; only a handshake updates them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_code   <= '0;
            out_addr   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (take) begin
            out_code   <= enc_code ^ flip;
            out_addr   <= sel_addr;
            out_src    <= grant;
            last_grant <= grant;
        end
    end

    // Completed output handshake counter, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (out_valid && out_ready && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ecc_write_arbiter.sv
module tb_ecc_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [7:0]  req0_addr, req1_addr;
    logic        out_valid, out_ready;
    logic [37:0] out_code;
    logic [7:0]  out_addr;
    logic        out_src;
    logic        err_inj_en;
    logic [5:0]  err_inj_pos;
    logic [15:0] word_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [37:0] CODE_ONES = 38'h3F7FFFFFF6;
    localparam logic [37:0] CODE_ONE  = 38'h0000000005;

    ecc_write_arbiter #(.ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_addr   (req0_addr),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_addr   (req1_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_addr    (out_addr),
        .out_src     (out_src),
        .err_inj_en  (err_inj_en),
        .err_inj_pos (err_inj_pos),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word from a single requester, consumed the following cycle
    task automatic send(input bit src, input logic [31:0] d, input logic [7:0] a,
                        input logic [37:0] exp_code, input string tag);
        if (src) begin req1_valid = 1'b1; req1_data = d; req1_addr = a; end
        else     begin req0_valid = 1'b1; req0_data = d; req0_addr = a; end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_vld"},  64'(out_valid), 64'd1);
        chk({tag, "_code"}, 64'(out_code),  64'(exp_code));
        chk({tag, "_src"},  64'(out_src),   64'(src));
        chk({tag, "_addr"}, 64'(out_addr),  64'(a));
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_addr = '0; req1_addr = '0;
        out_ready = 1'b1; err_inj_en = 1'b0; err_inj_pos = '0;
        tick(); tick();

        // Reset state; no grant while held in reset
        req0_valid = 1'b1;
        #1;
        chk("rst_vld",   64'(out_valid),  64'd0);
        chk("rst_cnt",   64'(word_cnt),   64'd0);
        chk("rst_code",  64'(out_code),   64'd0);
        chk("rst_rdy0",  64'(req0_ready), 64'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        req0_valid = 1'b1;
        #1;
        chk("post_rst_rdy0", 64'(req0_ready), 64'd1);
        req0_valid = 1'b0;

        // Single request and encode vectors
        send(1'b0, 32'h00000000, 8'h11, 38'h0, "single0");
        chk("cnt_1", 64'(word_cnt), 64'd1);
        send(1'b1, 32'hFFFFFFFF, 8'h22, CODE_ONES, "enc_ones");
        send(1'b1, 32'h00000001, 8'h23, CODE_ONE, "enc_one");
        chk("cnt_3", 64'(word_cnt), 64'd3);

        // Contention: last grant was req1, so grants go 0,1,0,1
        req0_valid = 1'b1; req0_data = 32'h1; req0_addr = 8'h30;
        req1_valid = 1'b1; req1_data = 32'h1; req1_addr = 8'h31;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_rdy0_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
            chk($sformatf("cont_rdy1_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
            tick();
            chk($sformatf("cont_src_%0d", i),  64'(out_src),  64'(i % 2));
            chk($sformatf("cont_addr_%0d", i), 64'(out_addr), 64'(8'h30 + 8'(i % 2)));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("cont_cnt",   64'(word_cnt),  64'd7);
        chk("cont_empty", 64'(out_valid), 64'd0);

        // Backpressure: one word captured, then both readies low and output held
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 32'h1; req0_addr = 8'h40;
        req1_valid = 1'b1; req1_data = 32'hFFFFFFFF; req1_addr = 8'h41;
        tick();
        chk("bp_rdy0",  64'(req0_ready), 64'd0);
        chk("bp_rdy1",  64'(req1_ready), 64'd0);
        chk("bp_code",  64'(out_code),   64'(CODE_ONE));
        tick();
        chk("bp_hold_code", 64'(out_code),  64'(CODE_ONE));
        chk("bp_hold_src",  64'(out_src),   64'd0);
        chk("bp_hold_cnt",  64'(word_cnt),  64'd7);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy1", 64'(req1_ready), 64'd1);
        chk("bp_rel_rdy0", 64'(req0_ready), 64'd0);
        tick();
        chk("b2b_code1", 64'(out_code), 64'(CODE_ONES));
        chk("b2b_src1",  64'(out_src),  64'd1);
        chk("b2b_cnt1",  64'(word_cnt), 64'd8);
        tick();
        chk("b2b_code2", 64'(out_code), 64'(CODE_ONE));
        chk("b2b_src2",  64'(out_src),  64'd0);
        chk("b2b_cnt2",  64'(word_cnt), 64'd9);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("b2b_cnt3", 64'(word_cnt), 64'd10);

        // Error injection, in range and out of range
        err_inj_en = 1'b1; err_inj_pos = 6'd5;
        send(1'b0, 32'h0, 8'h50, 38'h20, "inj5");
        err_inj_pos = 6'd40;
        send(1'b0, 32'h0, 8'h51, 38'h0, "inj40");
        err_inj_en = 1'b0;
        chk("inj_cnt", 64'(word_cnt), 64'd12);

        // Reset while holding a word from req0 (last grant = req0)
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 32'hFFFFFFFF; req0_addr = 8'h60;
        tick();
        req0_valid = 1'b0;
        chk("hold_vld", 64'(out_valid), 64'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",  64'(out_valid),  64'd0);
        chk("mid_rst_cnt",  64'(word_cnt),   64'd0);
        chk("mid_rst_code", 64'(out_code),   64'd0);
        chk("mid_rst_rdy0", 64'(req0_ready), 64'd0);
        chk("mid_rst_rdy1", 64'(req1_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("tie_rdy0", 64'(req0_ready), 64'd1);
        chk("tie_rdy1", 64'(req1_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("tie_src", 64'(out_src), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
